// File: rtl/imem_port_arbiter_pkg.sv
// Shared definitions for the instruction-memory port arbiter: response-tag
// encoding and default queue depth / starvation limit.
package imem_port_arbiter_pkg;

  localparam int MAXOUT_DEF = 4;
  localparam int STARVE_DEF = 8;

  typedef enum logic {
    ID_FETCH = 1'b0,
    ID_AUX   = 1'b1
  } tag_id_e;

  // One outstanding read: its owner and whether its response is to be discarded.
  typedef struct packed {
    tag_id_e id;
    logic    drop;
  } tag_t;

  function automatic tag_t new_tag(input tag_id_e id);
    return '{id: id, drop: 1'b0};
  endfunction

endpackage

// File: rtl/imem_tag_queue.sv
// In-order queue of response tags for outstanding imem reads; a flush can mark
// every fetch-owned entry as "drop" in a single cycle.
module imem_tag_queue
  import imem_port_arbiter_pkg::*;
#(
  parameter int DEPTH = MAXOUT_DEF
) (
  input  logic    clk,
  input  logic    reset,
  input  logic    push,
  input  tag_id_e push_id,
  input  logic    pop,
  input  logic    mark_drop,
  output tag_t    head,
  output logic    empty,
  output logic    full
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  tag_t          mem [DEPTH];

  // Extra wrap bit distinguishes full from empty when the index bits match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign head  = mem[rd_ptr[AW-1:0]];

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      // NOTE: the tag store is only a few flops and its drop bits must start
      // clear, so it is reset along with the pointers.
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (mark_drop) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (mem[i].id == ID_FETCH) begin
            mem[i].drop <= 1'b1;
          end
        end
      end
      // A push lands after the flush marking, so a freshly written slot starts clean.
      if (push && !full) begin
        mem[wr_ptr[AW-1:0]] <= new_tag(push_id);
        wr_ptr              <= wr_ptr + PW'(1);
      end
      if (pop && !empty) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
    end
  end

endmodule

// File: rtl/imem_port_arbiter.sv
// Shares one instruction-memory port between the fetch stage (port 0) and a
// secondary master (port 1); routes in-order read responses back to their owner.
module imem_port_arbiter
  import imem_port_arbiter_pkg::*;
#(
  parameter int IDATAW = 128,
  parameter int ISIZEW = 8,
  parameter int IADDRW = 32,
  parameter int MAXOUT = MAXOUT_DEF,
  parameter int STARVE = STARVE_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              r0_flush,
  input  logic              r0_valid,
  output logic              r0_ready,
  input  logic [IADDRW-1:0] r0_address,
  input  logic              r1_valid,
  output logic              r1_ready,
  input  logic [IADDRW-1:0] r1_address,
  input  logic              r1_wr_en,
  input  logic [IDATAW-1:0] r1_wr_data,
  input  logic [ISIZEW-1:0] r1_wr_size,
  output logic              r0_dp_valid,
  input  logic              r0_dp_ready,
  output logic [IDATAW-1:0] r0_dp_data,
  output logic              r1_dp_valid,
  input  logic              r1_dp_ready,
  output logic [IDATAW-1:0] r1_dp_data,
  output logic              imem_valid,
  input  logic              imem_ready,
  output logic [IADDRW-1:0] imem_address,
  output logic              imem_wr_en,
  output logic [IDATAW-1:0] imem_wr_data,
  output logic [ISIZEW-1:0] imem_wr_size,
  input  logic              imem_dp_valid,
  output logic              imem_dp_ready,
  input  logic [IDATAW-1:0] imem_dp_read_data
);

  localparam int SCW = $clog2(STARVE + 1);

  logic           arb_live;
  logic [SCW-1:0] starve_cnt;
  logic           starved;
  logic           r0_req;
  logic           gnt0;
  logic           gnt1;
  logic           issue_ok;
  logic           accept;
  logic           q_push;
  logic           q_pop;
  logic           q_empty;
  logic           q_full;
  tag_t           q_head;
  logic           discard;

  // Outputs are held at 0 from the moment reset asserts until the first clock
  // after it releases; the async clear keeps every output quiet mid-reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      arb_live <= 1'b0;
    end else begin
      arb_live <= 1'b1;
    end
  end

  // Grant: fetch has priority unless port 1 has waited STARVE cycles.
  assign starved = (starve_cnt == SCW'(STARVE));
  assign r0_req  = r0_valid && !r0_flush;
  assign gnt1    = r1_valid && (!r0_req || starved);
  assign gnt0    = r0_req && !gnt1;

  // Reads need a free tag slot; writes produce no response and bypass the limit.
  assign issue_ok   = gnt1 ? (r1_wr_en || !q_full) : (gnt0 && !q_full);
  assign imem_valid = arb_live && issue_ok;
  assign accept     = imem_valid && imem_ready;
  assign r0_ready   = accept && gnt0;
  assign r1_ready   = accept && gnt1;
  assign q_push     = accept && !(gnt1 && r1_wr_en);

  assign imem_address = !imem_valid ? '0 : (gnt1 ? r1_address : r0_address);
  assign imem_wr_en   = imem_valid && gnt1 && r1_wr_en;
  assign imem_wr_data = imem_wr_en ? r1_wr_data : '0;
  assign imem_wr_size = imem_wr_en ? r1_wr_size : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_cnt <= '0;
    end else if (r1_ready) begin
      starve_cnt <= '0;
    end else if (r1_valid && !starved) begin
      starve_cnt <= starve_cnt + SCW'(1);
    end
  end

  imem_tag_queue #(
    .DEPTH(MAXOUT)
  ) u_tag_queue (
    .clk      (clk),
    .reset    (reset),
    .push     (q_push),
    .push_id  (gnt1 ? ID_AUX : ID_FETCH),
    .pop      (q_pop),
    .mark_drop(r0_flush),
    .head     (q_head),
    .empty    (q_empty),
    .full     (q_full)
  );

  // A fetch response arriving in the flush cycle is already stale even though
  // its drop bit is only written at the coming edge.
  assign discard = q_head.drop || (r0_flush && (q_head.id == ID_FETCH));

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned and infers a latch.
  always_comb begin
    r0_dp_valid   = 1'b0;
    r1_dp_valid   = 1'b0;
    imem_dp_ready = 1'b0;
    if (arb_live && !q_empty) begin
      if (discard) begin
        imem_dp_ready = 1'b1;
      end else if (q_head.id == ID_FETCH) begin
        r0_dp_valid   = imem_dp_valid;
        imem_dp_ready = r0_dp_ready;
      end else begin
        r1_dp_valid   = imem_dp_valid;
        imem_dp_ready = r1_dp_ready;
      end
    end
  end

  assign q_pop      = imem_dp_valid && imem_dp_ready;
  assign r0_dp_data = r0_dp_valid ? imem_dp_read_data : '0;
  assign r1_dp_data = r1_dp_valid ? imem_dp_read_data : '0;

endmodule
